sweep_top_ctrl: RTL

Sequencer that exhaustively exercises the two-input, one-output combinational unit `top` (inputs `mtpx`, `mtpy`; output `mtpz`) and captures its truth table. On a start request it drives the four input combinations in ascending order and waits a programmable settle time before sampling each result. It assembles the 4-bit truth table, reports completion with a one-cycle pulse and, optionally, compares the table against an expected value. It sits beside a `top` instance in the lab harness: its drive outputs connect to `mtpx`/`mtpy`, and `mtpz` returns on `dut_z`.

---
 rtl/sweep_top_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/sweep_top_ctrl.sv
// rtl/sweep_top_ctrl.sv - truth-table sweep sequencer for the two-input unit "top"
// Optional table check enabled by defining SWEEP_TOP_CHECK_EN.
module sweep_top_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       drv_x,
  output logic       drv_y,
  input  logic       dut_z,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  input  logic [3:0] expected,
  output logic       mismatch
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       check_fail;

`ifdef SWEEP_TOP_CHECK_EN
  // The last bit is still on dut_z when DONE is entered, so fold it in here.
  assign check_fail = ({dut_z, truth_table[2:0]} != expected);
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign check_fail      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      cnt         <= 4'd0;
      drv_x       <= 1'b0;
      drv_y       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 4'b0000;
      mismatch    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            truth_table    <= 4'b0000;
            mismatch       <= 1'b0;
            idx            <= 2'd0;
            cnt            <= 4'd0;
            {drv_x, drv_y} <= 2'b00;
            busy           <= 1'b1;
            state          <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= 4'd0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          truth_table[idx] <= dut_z;
          if (idx == 2'd3) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            mismatch <= check_fail;
            state    <= S_DONE;
          end else begin
            // Next vector goes out on the same edge so DRIVE starts with it applied.
            idx            <= idx + 2'd1;
            {drv_x, drv_y} <= idx + 2'd1;
            state          <= S_DRIVE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
